// File: rtl/mem_arbiter.sv
// Shares one memory command/response port between a fetch bus (ibus) and a load/store bus (dbus).
// Fixed priority (dbus first) by default; define MEM_ARBITER_RR_EN for round-robin arbitration.
module mem_arbiter #(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstf,
   input  logic [31:0] ibus_cmd_addr,
   input  logic        ibus_cmd_valid,
   output logic        ibus_cmd_ready,
   output logic [31:0] ibus_rsp_data,
   output logic        ibus_rsp_valid,
   input  logic [31:0] dbus_cmd_addr,
   input  logic [31:0] dbus_cmd_data,
   input  logic        dbus_cmd_we,
   input  logic [3:0]  dbus_cmd_size,
   input  logic        dbus_cmd_valid,
   output logic        dbus_cmd_ready,
   output logic [31:0] dbus_rsp_data,
   output logic        dbus_rsp_valid,
   output logic [31:0] mem_cmd_addr,
   output logic [31:0] mem_cmd_data,
   output logic        mem_cmd_we,
   output logic [3:0]  mem_cmd_size,
   output logic        mem_cmd_valid,
   input  logic        mem_cmd_ready,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_valid,
   output logic        rsp_timeout
);
   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2} state_t;
   typedef enum logic {GNT_IBUS = 1'b0, GNT_DBUS = 1'b1} grant_t;

   localparam logic [15:0] TIMEOUT = 16'(RSP_TIMEOUT);

   state_t      state_q, state_d;
   grant_t      grant_q, grant_d;
   logic [15:0] cnt_q, cnt_d;
   grant_t      pick;

`ifdef MEM_ARBITER_RR_EN
   grant_t last_q, last_d;

   // On contention the requester that did not win last time gets the grant.
   always_comb begin
      last_d = last_q;
      if (dbus_cmd_valid && ibus_cmd_valid) begin
         pick = (last_q == GNT_DBUS) ? GNT_IBUS : GNT_DBUS;
      end else begin
         pick = dbus_cmd_valid ? GNT_DBUS : GNT_IBUS;
      end
      if (state_q == IDLE && (dbus_cmd_valid || ibus_cmd_valid)) begin
         last_d = pick;
      end
   end
`else
   always_comb begin
      pick = dbus_cmd_valid ? GNT_DBUS : GNT_IBUS;
   end
`endif

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      cnt_d          = cnt_q;
      ibus_cmd_ready = 1'b0;
      ibus_rsp_data  = '0;
      ibus_rsp_valid = 1'b0;
      dbus_cmd_ready = 1'b0;
      dbus_rsp_data  = '0;
      dbus_rsp_valid = 1'b0;
      mem_cmd_addr   = '0;
      mem_cmd_data   = '0;
      mem_cmd_we     = 1'b0;
      mem_cmd_size   = '0;
      mem_cmd_valid  = 1'b0;
      rsp_timeout    = 1'b0;
      case (state_q)
         IDLE: begin
            if (dbus_cmd_valid || ibus_cmd_valid) begin
               grant_d = pick;
               state_d = CMD;
            end
         end
         CMD: begin
            mem_cmd_valid = 1'b1;
            if (grant_q == GNT_DBUS) begin
               mem_cmd_addr   = dbus_cmd_addr;
               mem_cmd_data   = dbus_cmd_data;
               mem_cmd_we     = dbus_cmd_we;
               mem_cmd_size   = dbus_cmd_size;
               dbus_cmd_ready = mem_cmd_ready;
            end else begin
               mem_cmd_addr   = ibus_cmd_addr;
               mem_cmd_size   = 4'b1111;
               ibus_cmd_ready = mem_cmd_ready;
            end
            if (mem_cmd_ready) begin
               if (grant_q == GNT_DBUS && dbus_cmd_we) begin
                  state_d = IDLE;
               end else begin
                  state_d = RSP;
                  cnt_d   = '0;
               end
            end
         end
         RSP: begin
            // Once the wait count has been reached the read is dead, even if data shows up now.
            if (cnt_q == TIMEOUT) begin
               rsp_timeout = 1'b1;
               if (grant_q == GNT_DBUS) dbus_rsp_valid = 1'b1;
               else                     ibus_rsp_valid = 1'b1;
               state_d = IDLE;
            end else if (mem_rsp_valid) begin
               if (grant_q == GNT_DBUS) begin
                  dbus_rsp_valid = 1'b1;
                  dbus_rsp_data  = mem_rsp_data;
               end else begin
                  ibus_rsp_valid = 1'b1;
                  ibus_rsp_data  = mem_rsp_data;
               end
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rstf) begin
      if (rstf) begin
         state_q <= IDLE;
         grant_q <= GNT_DBUS;
         cnt_q   <= '0;
`ifdef MEM_ARBITER_RR_EN
         last_q  <= GNT_IBUS;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
`ifdef MEM_ARBITER_RR_EN
         last_q  <= last_d;
`endif
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed fetch/store/timeout/reset/contention cases
// plus randomized single-requester transactions against a transaction-level model.
module tb_mem_arbiter;
   localparam int T = 4;
`ifdef MEM_ARBITER_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstf;
   logic [31:0] ibus_cmd_addr;
   logic        ibus_cmd_valid;
   logic        ibus_cmd_ready;
   logic [31:0] ibus_rsp_data;
   logic        ibus_rsp_valid;
   logic [31:0] dbus_cmd_addr;
   logic [31:0] dbus_cmd_data;
   logic        dbus_cmd_we;
   logic [3:0]  dbus_cmd_size;
   logic        dbus_cmd_valid;
   logic        dbus_cmd_ready;
   logic [31:0] dbus_rsp_data;
   logic        dbus_rsp_valid;
   logic [31:0] mem_cmd_addr;
   logic [31:0] mem_cmd_data;
   logic        mem_cmd_we;
   logic [3:0]  mem_cmd_size;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_valid;
   logic        rsp_timeout;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [31:0] exp_q[$];

   mem_arbiter #(.RSP_TIMEOUT(T)) dut (
      .clk(clk), .rstf(rstf),
      .ibus_cmd_addr(ibus_cmd_addr), .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
      .ibus_rsp_data(ibus_rsp_data), .ibus_rsp_valid(ibus_rsp_valid),
      .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_we(dbus_cmd_we),
      .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
      .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_valid(dbus_rsp_valid),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data), .mem_cmd_we(mem_cmd_we),
      .mem_cmd_size(mem_cmd_size), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_valid(mem_rsp_valid), .rsp_timeout(rsp_timeout)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic drive_idle();
      ibus_cmd_addr  = '0;
      ibus_cmd_valid = 1'b0;
      dbus_cmd_addr  = '0;
      dbus_cmd_data  = '0;
      dbus_cmd_we    = 1'b0;
      dbus_cmd_size  = '0;
      dbus_cmd_valid = 1'b0;
      mem_cmd_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctrl"}, 32'({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready,
                                 ibus_rsp_valid, dbus_rsp_valid, rsp_timeout}), 32'd0);
      check({tag, "_data"}, mem_cmd_addr | mem_cmd_data | ibus_rsp_data | dbus_rsp_data |
                            32'({mem_cmd_we, mem_cmd_size}), 32'd0);
   endtask

   // Each driver task starts and ends 1 time unit after a rising edge with the arbiter idle.
   task automatic apply_reset();
      drive_idle();
      rstf = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1;
      rstf = 1'b0;
   endtask

   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] size,
                          input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      bit          is_read;
      bit          done;
      int          last;
      logic [31:0] exp_data;
      logic [3:0]  exp_size;
      is_read  = !(is_d && we);
      exp_data = is_d ? wdata : 32'd0;
      exp_size = is_d ? size : 4'b1111;
      if (is_d) begin
         dbus_cmd_addr  = addr;
         dbus_cmd_data  = wdata;
         dbus_cmd_we    = we;
         dbus_cmd_size  = size;
         dbus_cmd_valid = 1'b1;
      end else begin
         ibus_cmd_addr  = addr;
         ibus_cmd_valid = 1'b1;
      end
      @(negedge clk);
      check_quiet("idle");
      for (int i = 0; i <= rdy_dly; i++) begin
         @(posedge clk); #1;
         mem_cmd_ready = (i == rdy_dly);
         @(negedge clk);
         check("cmd_valid", 32'(mem_cmd_valid), 32'd1);
         check("cmd_addr", mem_cmd_addr, addr);
         check("cmd_data", mem_cmd_data, exp_data);
         check("cmd_we_size", 32'({mem_cmd_we, mem_cmd_size}), 32'({is_d && we, exp_size}));
         check("owner_ready", 32'(is_d ? dbus_cmd_ready : ibus_cmd_ready), 32'(i == rdy_dly));
         check("other_ready", 32'(is_d ? ibus_cmd_ready : dbus_cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      drive_idle();
      if (!is_read) begin
         @(negedge clk);
         check_quiet("store_done");
         @(posedge clk); #1;
      end else begin
         exp_q.push_back((rsp_dly < T) ? rdata : 32'd0);
         last = (rsp_dly < T) ? rsp_dly : ((rsp_dly > T) ? rsp_dly : T);
         done = 1'b0;
         for (int i = 0; i <= last; i++) begin
            if (i > 0) begin
               @(posedge clk); #1;
            end
            mem_rsp_valid = (i == rsp_dly);
            mem_rsp_data  = (i == rsp_dly) ? rdata : $urandom;
            @(negedge clk);
            if (!done && ((i == rsp_dly && rsp_dly < T) || i == T)) begin
               check("rsp_valid", 32'(is_d ? dbus_rsp_valid : ibus_rsp_valid), 32'd1);
               check("rsp_data", is_d ? dbus_rsp_data : ibus_rsp_data, exp_q.pop_front());
               check("rsp_timeout", 32'(rsp_timeout), 32'(i == T));
               check("other_rsp", is_d ? (ibus_rsp_data | 32'(ibus_rsp_valid))
                                       : (dbus_rsp_data | 32'(dbus_rsp_valid)), 32'd0);
               done = 1'b1;
            end else begin
               check_quiet(done ? "late_rsp" : "rsp_wait");
            end
         end
         @(posedge clk); #1;
         drive_idle();
      end
   endtask

   task automatic run_contention(input int n);
      bit last_was_d;
      bit exp_d;
      last_was_d     = 1'b0;
      ibus_cmd_addr  = 32'h0000_1000;
      ibus_cmd_valid = 1'b1;
      dbus_cmd_addr  = 32'h0000_2000;
      dbus_cmd_we    = 1'b0;
      dbus_cmd_size  = 4'b1111;
      dbus_cmd_valid = 1'b1;
      for (int k = 0; k < n; k++) begin
         exp_d      = RR_MODE ? !last_was_d : 1'b1;
         last_was_d = exp_d;
         @(negedge clk);
         check("arb_idle", 32'(mem_cmd_valid), 32'd0);
         @(posedge clk); #1;
         mem_cmd_ready = 1'b1;
         @(negedge clk);
         check("arb_addr", mem_cmd_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
         check("arb_ready", 32'({dbus_cmd_ready, ibus_cmd_ready}), 32'({exp_d, !exp_d}));
         @(posedge clk); #1;
         mem_cmd_ready = 1'b0;
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 32'hC0DE_0000 + 32'(k);
         @(negedge clk);
         check("arb_rsp", 32'({dbus_rsp_valid, ibus_rsp_valid}), 32'({exp_d, !exp_d}));
         check("arb_rsp_data", exp_d ? dbus_rsp_data : ibus_rsp_data, 32'hC0DE_0000 + 32'(k));
         @(posedge clk); #1;
         mem_rsp_valid = 1'b0;
      end
      drive_idle();
   endtask

   task automatic reset_mid_rsp();
      dbus_cmd_addr  = 32'h0000_0400;
      dbus_cmd_we    = 1'b0;
      dbus_cmd_size  = 4'b0001;
      dbus_cmd_valid = 1'b1;
      @(posedge clk); #1;
      mem_cmd_ready = 1'b1;
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_quiet("rst_wait");
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hFEED_F00D;
      #1;
      check("rst_pre_rsp", dbus_rsp_data, 32'hFEED_F00D);
      rstf = 1'b1;
      #1;
      check_quiet("rst_async");
      @(posedge clk); #1;
      rstf = 1'b0;
      @(negedge clk);
      check_quiet("rst_late_rsp");
      @(posedge clk); #1;
      drive_idle();
   endtask

   initial begin
      int          sel;
      int          rd;
      logic [3:0]  sz;
      rstf = 1'b1;
      drive_idle();
      apply_reset();
      run_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'b1111, 0, 0, 32'hDEAD_BEEF);
      run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 4, 0, 32'd0);
      run_txn(1'b1, 1'b0, 32'h0000_0300, 32'hA5A5_A5A5, 4'b1111, 0, T + 2, 32'h55AA_55AA);
      run_txn(1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'b1111, 1, T - 1, 32'h0BAD_CAFE);
      reset_mid_rsp();
      apply_reset();
      run_contention(4);
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 2));
         sz  = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0011 : 4'b1111);
         rd  = ($urandom_range(0, 3) == 0) ? T + int'($urandom_range(1, 2))
                                           : int'($urandom_range(0, T - 1));
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, sz,
                 int'($urandom_range(0, 3)), rd, $urandom);
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RSP_TIMEOUT, default 255, giving the maximum cycles to wait for a read response (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstf  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ibus_cmd_addr  input  32  instruction-fetch read address.
REQ-005 SHALL have port ibus_cmd_valid  input  1  fetch request valid.
REQ-006 SHALL have port ibus_cmd_ready  output  1  fetch request accepted.
REQ-007 SHALL have port ibus_rsp_data  output  32  fetch read data.
REQ-008 SHALL have port ibus_rsp_valid  output  1  fetch response strobe, one cycle.
REQ-009 SHALL have port dbus_cmd_addr  input  32  load/store address.
REQ-010 SHALL have port dbus_cmd_data  input  32  store data.
REQ-011 SHALL have port dbus_cmd_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port dbus_cmd_size  input  4  byte-lane mask (0001, 0011, 1111).
REQ-013 SHALL have port dbus_cmd_valid  input  1  data request valid.
REQ-014 SHALL have port dbus_cmd_ready  output  1  data request accepted.
REQ-015 SHALL have port dbus_rsp_data  output  32  load data.
REQ-016 SHALL have port dbus_rsp_valid  output  1  load response strobe, one cycle.
REQ-017 SHALL have port mem_cmd_addr / mem_cmd_data  output  32 each  shared memory command address and data.
REQ-018 SHALL have port mem_cmd_we  output  1, and mem_cmd_size  output  4  shared command type and lane mask.
REQ-019 SHALL have port mem_cmd_valid  output  1, and mem_cmd_ready  input  1  shared command handshake.
REQ-020 SHALL have port mem_rsp_data  input  32, and mem_rsp_valid  input  1  shared read response.
REQ-021 SHALL have port rsp_timeout  output  1  one-cycle pulse when a read response times out.

Function
REQ-022 SHALL implement states IDLE, CMD and RSP, with a registered grant (IBUS/DBUS) and a 16-bit wait counter.
REQ-023 IDLE: if any cmd_valid, register the grant and go to CMD next cycle; otherwise stay in IDLE.
REQ-024 Arbitration with both valid SHALL be fixed priority, dbus over ibus.
REQ-025 CMD: mem_cmd_valid=1; mem_cmd_* driven from the granted requester; ibus treated as we=0, data=0, size=1111.
REQ-026 CMD: the granted requester's cmd_ready = mem_cmd_ready; the other requester's cmd_ready=0.
REQ-027 On the CMD handshake: a store returns to IDLE with no response; a load or fetch goes to RSP with counter cleared.
REQ-028 RSP: mem_rsp_valid SHALL pass combinationally to the granted requester's rsp_valid with mem_rsp_data in the same cycle, then return to IDLE.
REQ-029 RSP: the counter increments each cycle without a response; when it reaches RSP_TIMEOUT, pulse rsp_timeout and the owner's rsp_valid with data 0, then return to IDLE.
REQ-030 mem_rsp_valid outside RSP SHALL be ignored, including late responses after a timeout.
REQ-031 Outside CMD, mem_cmd_valid=0, all cmd_ready=0, and mem_cmd_* SHALL be 0.
REQ-032 Outside a response cycle, rsp_valid=0 and rsp_data=0 for both requesters.
REQ-033 Latency SHALL be a minimum of 3 cycles per read (IDLE, CMD, RSP) and 2 per store; a requester must hold its fields stable until ready.

Reset
REQ-034 Asserting rstf SHALL immediately force IDLE, grant=DBUS, counter=0 and all outputs to 0, including mid-transaction.
REQ-035 A transaction in flight at reset SHALL be abandoned; its late response is dropped per REQ-030.

Configuration
REQ-036 With MEM_ARBITER_RR_EN defined, arbitration SHALL be round-robin: on contention, grant the requester not granted last; the last-grant pointer resets to ibus, so dbus wins first.
REQ-037 Without MEM_ARBITER_RR_EN, arbitration SHALL be fixed priority per REQ-024.

Verification
REQ-038 Fetch 0x100 with memory ready and responding 0xDEADBEEF the cycle after CMD -> ibus_rsp_valid for one cycle with 0xDEADBEEF, 3 cycles total.
REQ-039 Store of 0x12345678 to 0x200 with size 0011 and mem_cmd_ready held low 4 cycles -> mem_cmd_valid held 4+1 cycles, dbus_cmd_ready=1 only on the handshake cycle, no rsp_valid.
REQ-040 Fetch and load both valid for 4 consecutive transactions -> fixed priority: dbus every time; with MEM_ARBITER_RR_EN: dbus, ibus, dbus, ibus.
REQ-041 Read with RSP_TIMEOUT=4 and no response -> rsp_timeout and owner rsp_valid with data 0 after 4 RSP cycles; a response 2 cycles later is ignored.
REQ-042 rstf asserted in RSP of a load -> outputs 0 immediately; the subsequent mem_rsp_valid produces no dbus_rsp_valid.
